// File: rtl/axis_tx_pkt_gen.sv
// axis_tx_pkt_gen: AXI-Stream master that emits bursts of numbered packets
// whose payload bytes follow a closed-form pattern, so a receiver can check
// them without a stored copy of the data:
//    byte(n, k) = (seed + n[7:0] + k[7:0]) mod 256
// where n is the packet index within the burst and k the byte index within
// the packet.
//
// Ports:
//   tx_mac_aclk         single clock
//   reset               synchronous, active-high
//   start               one-cycle burst request, honoured only when idle
//   num_pkts/pkt_len/ipg/seed  burst parameters, captured on an accepted start
//   tx_axis_mac_*       AXIS master towards the MAC TX slave; tbcnt carries
//                       the packet length while tvalid is high
//   busy                burst in progress
//   done                one-cycle pulse when a burst ends (incl. empty burst)
//   pkt_cnt             packets completed since the last accepted start
module axis_tx_pkt_gen #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BCNT_WIDTH = 32
) (
   input  logic                      tx_mac_aclk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [15:0]               num_pkts,
   input  logic [15:0]               pkt_len,
   input  logic [7:0]                ipg,
   input  logic [7:0]                seed,
   output logic [DATA_WIDTH-1:0]     tx_axis_mac_tdata,
   output logic [DATA_WIDTH/8-1:0]   tx_axis_mac_tkeep,
   output logic                      tx_axis_mac_tvalid,
   output logic                      tx_axis_mac_tlast,
   input  logic                      tx_axis_mac_tready,
   output logic [BCNT_WIDTH-1:0]     tx_axis_mac_tbcnt,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               pkt_cnt
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
   } beat_t;

   // Builds the beat whose first byte index is b_k; lanes past the packet end
   // are zero with keep cleared, and the beat is last when it reaches pkt end.
   function automatic beat_t make_beat(input logic [7:0]  b_seed,
                                       input logic [15:0] b_n,
                                       input logic [15:0] b_k,
                                       input logic [15:0] b_len);
      beat_t       b;
      logic [16:0] remaining;
      remaining = {1'b0, b_len} - {1'b0, b_k};
      b.data    = '0;
      b.keep    = '0;
      b.last    = (remaining <= 17'(KEEP_WIDTH));
      for (int j = 0; j < KEEP_WIDTH; j++) begin
         if (17'(j) < remaining) begin
            b.keep[j]        = 1'b1;
            b.data[8*j +: 8] = b_seed + b_n[7:0] + b_k[7:0] + 8'(j);
         end
      end
      return b;
   endfunction

   state_t                state_q, state_d;
   logic [15:0]           num_pkts_q, num_pkts_d;
   logic [15:0]           pkt_len_q, pkt_len_d;
   logic [7:0]            ipg_q, ipg_d;
   logic [7:0]            seed_q, seed_d;
   logic [15:0]           n_q, n_d;
   logic [15:0]           k_q, k_d;
   logic [7:0]            gap_q, gap_d;
   logic [31:0]           pkt_cnt_d;
   logic [DATA_WIDTH-1:0] tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_d;
   logic                  tvalid_d;
   logic                  tlast_d;
   logic [BCNT_WIDTH-1:0] tbcnt_d;
   logic                  busy_d;
   logic                  done_d;

   // Per-cycle request to present a new beat, or to blank the output beat.
   logic                  load_beat;
   logic                  clear_beat;
   beat_t                 beat;
   logic [15:0]           beat_len;
   logic [15:0]           n_inc;

   assign n_inc = n_q + 16'd1;

   // State register and all registered outputs.
   always_ff @(posedge tx_mac_aclk) begin
      if (reset) begin
         state_q            <= IDLE;
         num_pkts_q         <= '0;
         pkt_len_q          <= '0;
         ipg_q              <= '0;
         seed_q             <= '0;
         n_q                <= '0;
         k_q                <= '0;
         gap_q              <= '0;
         pkt_cnt            <= '0;
         tx_axis_mac_tdata  <= '0;
         tx_axis_mac_tkeep  <= '0;
         tx_axis_mac_tvalid <= 1'b0;
         tx_axis_mac_tlast  <= 1'b0;
         tx_axis_mac_tbcnt  <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         state_q            <= state_d;
         num_pkts_q         <= num_pkts_d;
         pkt_len_q          <= pkt_len_d;
         ipg_q              <= ipg_d;
         seed_q             <= seed_d;
         n_q                <= n_d;
         k_q                <= k_d;
         gap_q              <= gap_d;
         pkt_cnt            <= pkt_cnt_d;
         tx_axis_mac_tdata  <= tdata_d;
         tx_axis_mac_tkeep  <= tkeep_d;
         tx_axis_mac_tvalid <= tvalid_d;
         tx_axis_mac_tlast  <= tlast_d;
         tx_axis_mac_tbcnt  <= tbcnt_d;
         busy               <= busy_d;
         done               <= done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      num_pkts_d = num_pkts_q;
      pkt_len_d  = pkt_len_q;
      ipg_d      = ipg_q;
      seed_d     = seed_q;
      n_d        = n_q;
      k_d        = k_q;
      gap_d      = gap_q;
      pkt_cnt_d  = pkt_cnt;
      tdata_d    = tx_axis_mac_tdata;
      tkeep_d    = tx_axis_mac_tkeep;
      tvalid_d   = tx_axis_mac_tvalid;
      tlast_d    = tx_axis_mac_tlast;
      tbcnt_d    = tx_axis_mac_tbcnt;
      done_d     = 1'b0;
      load_beat  = 1'b0;
      clear_beat = 1'b0;
      beat       = '0;
      beat_len   = pkt_len_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               num_pkts_d = num_pkts;
               pkt_len_d  = pkt_len;
               ipg_d      = ipg;
               seed_d     = seed;
               n_d        = '0;
               k_d        = '0;
               pkt_cnt_d  = '0;
               if ((num_pkts == 16'd0) || (pkt_len == 16'd0)) begin
                  done_d = 1'b1;
               end else begin
                  // Parameters are not yet registered, so beat 0 is built
                  // straight from the inputs.
                  state_d   = SEND;
                  load_beat = 1'b1;
                  beat_len  = pkt_len;
                  beat      = make_beat(seed, 16'd0, 16'd0, pkt_len);
               end
            end
         end

         SEND: begin
            // tvalid is always high here, so tready alone is the handshake.
            if (tx_axis_mac_tready) begin
               if (tx_axis_mac_tlast) begin
                  pkt_cnt_d = pkt_cnt + 32'd1;
                  n_d       = n_inc;
                  k_d       = '0;
                  if (n_inc == num_pkts_q) begin
                     state_d    = IDLE;
                     done_d     = 1'b1;
                     clear_beat = 1'b1;
                  end else if (ipg_q == 8'd0) begin
                     load_beat = 1'b1;
                     beat      = make_beat(seed_q, n_inc, 16'd0, pkt_len_q);
                  end else begin
                     state_d    = GAP;
                     gap_d      = ipg_q;
                     clear_beat = 1'b1;
                  end
               end else begin
                  k_d       = k_q + 16'(KEEP_WIDTH);
                  load_beat = 1'b1;
                  beat      = make_beat(seed_q, n_q, k_d, pkt_len_q);
               end
            end
         end

         GAP: begin
            // Counter holds the idle cycles left including this one.
            if (gap_q == 8'd1) begin
               state_d   = SEND;
               load_beat = 1'b1;
               beat      = make_beat(seed_q, n_q, 16'd0, pkt_len_q);
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end

         default: begin
            state_d    = IDLE;
            clear_beat = 1'b1;
         end
      endcase

      if (load_beat) begin
         tdata_d  = beat.data;
         tkeep_d  = beat.keep;
         tlast_d  = beat.last;
         tvalid_d = 1'b1;
         tbcnt_d  = BCNT_WIDTH'(beat_len);
      end else if (clear_beat) begin
         tdata_d  = '0;
         tkeep_d  = '0;
         tlast_d  = 1'b0;
         tvalid_d = 1'b0;
         tbcnt_d  = '0;
      end

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_axis_tx_pkt_gen.sv
// Directed bench for axis_tx_pkt_gen: a reference model pushes every expected
// beat into a queue when a burst is started, a negedge monitor pops and
// compares on each handshake, and the main sequence checks timing directly.
module tb_axis_tx_pkt_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] num_pkts;
   logic [15:0] pkt_len;
   logic [7:0]  ipg;
   logic [7:0]  seed;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tready;
   logic [31:0] tbcnt;
   logic        busy;
   logic        done;
   logic [31:0] pkt_cnt;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [31:0] c;
   } exp_beat_t;

   exp_beat_t exp_q[$];
   exp_beat_t mon_e;

   always #5 clk = ~clk;

   axis_tx_pkt_gen #(.DATA_WIDTH(64), .BCNT_WIDTH(32)) dut (
      .tx_mac_aclk        (clk),
      .reset              (reset),
      .start              (start),
      .num_pkts           (num_pkts),
      .pkt_len            (pkt_len),
      .ipg                (ipg),
      .seed               (seed),
      .tx_axis_mac_tdata  (tdata),
      .tx_axis_mac_tkeep  (tkeep),
      .tx_axis_mac_tvalid (tvalid),
      .tx_axis_mac_tlast  (tlast),
      .tx_axis_mac_tready (tready),
      .tx_axis_mac_tbcnt  (tbcnt),
      .busy               (busy),
      .done               (done),
      .pkt_cnt            (pkt_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: one entry per beat, bytes built lane by lane.
   task automatic push_burst(input logic [7:0] s, input int np, input int len);
      exp_beat_t e;
      for (int n = 0; n < np; n++) begin
         for (int kb = 0; kb < len; kb += 8) begin
            e   = '0;
            e.c = 32'(len);
            e.l = (kb + 8 >= len);
            for (int j = 0; j < 8; j++) begin
               if (kb + j < len) begin
                  e.k[j]        = 1'b1;
                  e.d[8*j +: 8] = s + 8'(n) + 8'(kb + j);
               end
            end
            exp_q.push_back(e);
         end
      end
   endtask

   // Called just after a posedge; returns just after the accepting edge.
   task automatic do_start(input logic [7:0] s, input int np, input int len, input int g);
      push_burst(s, np, len);
      seed     = s;
      num_pkts = 16'(np);
      pkt_len  = 16'(len);
      ipg      = 8'(g);
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Bounded wait for the done pulse, then checks its end-of-burst context.
   task automatic wait_done(input string tag, input int max_cyc, input int exp_pkts);
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'(1));
      if (seen) begin
         chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
         chk({tag, "_tvalid_at_done"}, 64'(tvalid), 64'(0));
         chk({tag, "_pkt_cnt_at_done"}, 64'(pkt_cnt), 64'(exp_pkts));
      end
      step();
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
      step();
   endtask

   // Scoreboard monitor: compares every handshaked beat with the model.
   always @(negedge clk) begin
      if (reset === 1'b0 && tvalid === 1'b1 && tready === 1'b1) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(1), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat_tdata", tdata, mon_e.d);
            chk("beat_tkeep", 64'(tkeep), 64'(mon_e.k));
            chk("beat_tlast", 64'(tlast), 64'(mon_e.l));
            chk("beat_tbcnt", 64'(tbcnt), 64'(mon_e.c));
         end
      end
   end

   initial begin
      logic exp_v;
      logic exp_l;

      reset    = 1'b1;
      start    = 1'b0;
      num_pkts = '0;
      pkt_len  = '0;
      ipg      = '0;
      seed     = '0;
      tready   = 1'b1;
      step();
      @(negedge clk);
      chk("rst_tvalid", 64'(tvalid), 64'(0));
      chk("rst_tlast", 64'(tlast), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_tdata", tdata, 64'(0));
      chk("rst_tkeep", 64'(tkeep), 64'(0));
      chk("rst_tbcnt", 64'(tbcnt), 64'(0));
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
      step();
      reset = 1'b0;
      step();

      // Single 13-byte packet.
      do_start(8'h10, 1, 13, 0);
      @(negedge clk);
      chk("p13_b0_tvalid", 64'(tvalid), 64'(1));
      chk("p13_b0_busy", 64'(busy), 64'(1));
      chk("p13_b0_tdata", tdata, 64'h17161514_13121110);
      chk("p13_b0_tkeep", 64'(tkeep), 64'hFF);
      chk("p13_b0_tlast", 64'(tlast), 64'(0));
      step();
      @(negedge clk);
      chk("p13_b1_tdata", tdata, 64'h0000001C_1B1A1918);
      chk("p13_b1_tkeep", 64'(tkeep), 64'h1F);
      chk("p13_b1_tlast", 64'(tlast), 64'(1));
      chk("p13_b1_tbcnt", 64'(tbcnt), 64'd13);
      step();
      @(negedge clk);
      chk("p13_done", 64'(done), 64'(1));
      chk("p13_busy", 64'(busy), 64'(0));
      chk("p13_tvalid", 64'(tvalid), 64'(0));
      chk("p13_tbcnt_idle", 64'(tbcnt), 64'(0));
      chk("p13_pkt_cnt", 64'(pkt_cnt), 64'd1);
      step();
      @(negedge clk);
      chk("p13_done_low", 64'(done), 64'(0));
      step();

      // Backpressure on beat 1 of a 24-byte packet.
      hs_cnt = 0;
      do_start(8'h33, 1, 24, 0);
      step();
      tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_tvalid", 64'(tvalid), 64'(1));
         chk("bp_hold_tdata", tdata, exp_q[0].d);
         chk("bp_hold_tkeep", 64'(tkeep), 64'(exp_q[0].k));
         chk("bp_hold_tlast", 64'(tlast), 64'(0));
         step();
      end
      tready = 1'b1;
      wait_done("bp", 10, 1);
      chk("bp_beats", 64'(hs_cnt), 64'd3);

      // Gap and pattern: 3 single-beat packets with 4 idle cycles between.
      do_start(8'h00, 3, 8, 4);
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         exp_v = (c == 0 || c == 5 || c == 10);
         chk("gap_tvalid", 64'(tvalid), 64'(exp_v));
         chk("gap_done", 64'(done), 64'(c == 11));
         if (c == 1)  chk("gap_pkt_cnt1", 64'(pkt_cnt), 64'd1);
         if (c == 6)  chk("gap_pkt_cnt2", 64'(pkt_cnt), 64'd2);
         if (c == 11) chk("gap_pkt_cnt3", 64'(pkt_cnt), 64'd3);
         if (c == 10) chk("gap_pkt2_byte0", 64'(tdata[7:0]), 64'h02);
         step();
      end

      // Back-to-back 9-byte packets.
      do_start(8'h55, 2, 9, 0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp_v = (c < 4);
         exp_l = (c == 1 || c == 3);
         chk("b2b_tvalid", 64'(tvalid), 64'(exp_v));
         chk("b2b_tlast", 64'(tlast), 64'(exp_l));
         if (exp_l) chk("b2b_last_tkeep", 64'(tkeep), 64'h01);
         chk("b2b_done", 64'(done), 64'(c == 4));
         if (c == 4) chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'd2);
         step();
      end

      // Degenerate starts: empty packet length, then zero packets.
      do_start(8'h01, 5, 0, 2);
      @(negedge clk);
      chk("deg_len_done", 64'(done), 64'(1));
      chk("deg_len_busy", 64'(busy), 64'(0));
      chk("deg_len_tvalid", 64'(tvalid), 64'(0));
      chk("deg_len_pkt_cnt", 64'(pkt_cnt), 64'(0));
      step();
      @(negedge clk);
      chk("deg_len_done_low", 64'(done), 64'(0));
      chk("deg_len_busy_low", 64'(busy), 64'(0));
      step();
      do_start(8'h01, 0, 8, 0);
      @(negedge clk);
      chk("deg_np_done", 64'(done), 64'(1));
      chk("deg_np_busy", 64'(busy), 64'(0));
      step();

      // Start while busy is ignored.
      hs_cnt = 0;
      do_start(8'h20, 2, 16, 3);
      step();
      seed     = 8'hEE;
      num_pkts = 16'd7;
      pkt_len  = 16'd1;
      ipg      = 8'd0;
      start    = 1'b1;
      step();
      start    = 1'b0;
      @(negedge clk);
      chk("ign_busy", 64'(busy), 64'(1));
      chk("ign_pkt_cnt", 64'(pkt_cnt), 64'd1);
      step();
      wait_done("ign", 30, 2);
      chk("ign_beats", 64'(hs_cnt), 64'd4);

      // Reset during beat 1 of a 40-byte packet.
      do_start(8'h77, 1, 40, 0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mrst_tvalid", 64'(tvalid), 64'(0));
      chk("mrst_tlast", 64'(tlast), 64'(0));
      chk("mrst_tdata", tdata, 64'(0));
      chk("mrst_tkeep", 64'(tkeep), 64'(0));
      chk("mrst_tbcnt", 64'(tbcnt), 64'(0));
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_done", 64'(done), 64'(0));
      chk("mrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
      step();
      do_start(8'hA0, 1, 8, 0);
      @(negedge clk);
      chk("post_rst_byte0", 64'(tdata[7:0]), 64'hA0);
      chk("post_rst_pkt_cnt0", 64'(pkt_cnt), 64'(0));
      step();
      wait_done("post_rst", 5, 1);

      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_tx_pkt_gen.md
# axis_tx_pkt_gen

- Synthesizable AXI-Stream master that generates numbered, deterministic-pattern packets into the MAC TX stream interface.
- It is the transmit-side counterpart of the RX-side AXIS checkers: every payload byte is a closed-form function of seed, packet index and byte index, so a receive-side comparator can check it without a data file.
- It sits between the testbench/register control and the MAC TX AXIS slave port.

## Interface
Parameters:
- DATA_WIDTH, 64, stream data width in bits. Only 64 is supported (8 byte lanes).
- BCNT_WIDTH, 32, width of tx_axis_mac_tbcnt.

Ports:
- tx_mac_aclk  input  1  TX clock. The block has one clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst. Sampled only in IDLE.
- num_pkts  input  16  number of packets in the burst. Sampled on an accepted start.
- pkt_len  input  16  bytes per packet. Sampled on an accepted start.
- ipg  input  8  idle cycles between packets. Sampled on an accepted start.
- seed  input  8  pattern seed. Sampled on an accepted start.
- tx_axis_mac_tdata  output  DATA_WIDTH  payload. Lane j (bits 8j+7:8j) carries the byte with the lower index within the beat.
- tx_axis_mac_tkeep  output  DATA_WIDTH/8  byte-lane valid.
- tx_axis_mac_tvalid  output  1  beat valid.
- tx_axis_mac_tlast  output  1  last beat of the packet.
- tx_axis_mac_tready  input  1  sink ready.
- tx_axis_mac_tbcnt  output  BCNT_WIDTH  packet byte count. Equals the zero-extended pkt_len while tvalid=1; 0 otherwise.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst end.
- pkt_cnt  output  32  packets completed (tlast handshakes) since the last accepted start.

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - An accepted start latches num_pkts, pkt_len, ipg and seed, and clears pkt_cnt, packet index n and byte index k.
  - If the latched num_pkts=0 or pkt_len=0: stay in IDLE and pulse done the next cycle. busy never asserts.
  - Otherwise go to SEND and assert busy.
- SEND:
  - tvalid=1. Beat b of packet n carries bytes k=8b..8b+7.
  - Byte value = (seed + n[7:0] + k[7:0]) mod 256.
  - Beats per packet = ceil(pkt_len/8). k counts to 16 bits.
  - Non-last beats: tkeep=8'hFF.
  - Last beat: tlast=1 and tkeep=(1<<r)-1, where r=pkt_len mod 8. When r=0, tkeep=8'hFF.
  - Lanes with tkeep=0 drive 8'h00.
  - A handshake is tvalid && tready. Only a handshake advances the beat.
  - While tvalid=1 and tready=0, tdata, tkeep, tlast and tbcnt hold stable.
- On a tlast handshake:
  - pkt_cnt and n increment; k clears.
  - If n+1 = num_pkts: go to IDLE, drop busy, pulse done.
  - Else if ipg=0: stay in SEND. The next packet's first beat is presented in the following cycle (back-to-back).
  - Else go to GAP.
- GAP:
  - tvalid=0 for exactly ipg cycles, counted by an 8-bit down-counter.
  - Then return to SEND.
- start while busy (SEND or GAP) is ignored. Parameter inputs are also ignored while busy.
- n wraps at 2^16 internally. pkt_cnt is 32-bit and does not wrap within any legal burst.
- Reset:
  - Outputs: tvalid, tlast, busy and done = 0; tdata, tkeep, tbcnt and pkt_cnt = 0; state = IDLE.
  - Reset mid-packet abandons the packet with no tlast. The next start begins a fresh burst.

## Timing
- Start accepted at edge t: tvalid=1 with beat 0 from cycle t+1.
- Throughput is one beat per cycle while tready=1, including across packets when ipg=0.
- Final tlast handshake at edge t: in cycle t+1, tvalid=0, busy=0 and done=1 for exactly one cycle.
- Degenerate start (num_pkts=0 or pkt_len=0) at edge t: done=1 in cycle t+1.
- pkt_cnt is registered. It shows the new value the cycle after the tlast handshake.
- tready is not registered into the datapath. A skid buffer is not required.

## Test plan
- Single 13-byte packet:
  - Stimulus: seed=8'h10, num_pkts=1, ipg=0, tready=1.
  - Beat 0: bytes 10..17, tkeep=FF, tlast=0.
  - Beat 1: bytes 18..1C, lanes 5-7 =00, tkeep=1F, tlast=1, tbcnt=13.
  - done pulses in the following cycle; pkt_cnt=1.
- Backpressure:
  - Stimulus: pkt_len=24, tready low for 3 cycles on beat 1.
  - Beat 1 data and tkeep hold unchanged all 3 cycles. Exactly 3 beats are transferred, the last with tkeep=FF.
- Gap and pattern:
  - Stimulus: num_pkts=3, pkt_len=8, ipg=4, seed=0.
  - tvalid is low exactly 4 cycles between packets.
  - Packet 2, byte 0 = 8'h02.
  - pkt_cnt steps 1,2,3; done pulses after the third packet.
- Back-to-back:
  - Stimulus: num_pkts=2, ipg=0, pkt_len=9.
  - 4 consecutive valid cycles.
  - tlast on beats 1 and 3; both last beats have tkeep=01.
- Degenerate and ignored start:
  - pkt_len=0: done in the next cycle, busy stays 0.
  - start during a burst: no restart and no change to pkt_cnt.
- Reset mid-packet:
  - Stimulus: assert reset during beat 1 of a 40-byte packet.
  - All outputs are 0 the next cycle.
  - A new start with seed=8'hA0 produces first byte A0 and pkt_cnt restarts from 0.
